// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin sharing of the encoder/modulator path among byte sources,
// with start/done sequencing, an inter-frame guard gap and a watchdog abort counter.
module tx_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_W     = 8,
    parameter  int GAP_CYCLES = 2,
    parameter  int TIMEOUT    = 255,
    localparam int SRC_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    output logic [SRC_W-1:0]          tx_src,
    input  logic                      tx_done,
    output logic                      active,
    output logic                      timeout_err,
    output logic [7:0]                err_cnt
);
    typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;
    state_t              state_q;
    logic [SRC_W-1:0]    ptr_q;
    logic [SRC_W-1:0]    win;
    logic [NUM_REQ-1:0]  gnt_q;
    logic                tx_start_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic [SRC_W-1:0]    tx_src_q;
    logic                active_q;
    logic                timeout_err_q;
    logic [7:0]          err_cnt_q;
    logic [7:0]          timer_q;
    logic [7:0]          timer_d;
    logic [3:0]          gap_q;
    logic [3:0]          gap_d;
    logic                busy_exit;
    int                  idx;
    // Scan from the pointer upward; iterating backwards leaves the first hit in win.
    always_comb begin
        win = '0;
        idx = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            idx = idx >= NUM_REQ ? idx - NUM_REQ : idx;
            if (req[SRC_W'(idx)]) win = SRC_W'(idx);
        end
    end
    assign timer_d   = timer_q + 8'd1;
    assign gap_d     = gap_q + 4'd1;
    assign busy_exit = tx_done || timer_d == 8'(TIMEOUT);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            gnt_q         <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            tx_src_q      <= '0;
            active_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            err_cnt_q     <= '0;
            timer_q       <= '0;
            gap_q         <= '0;
        end else begin
            gnt_q         <= '0;
            tx_start_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: if (en && |req) begin
                    state_q    <= START;
                    gnt_q      <= NUM_REQ'(1) << win;
                    tx_start_q <= 1'b1;
                    active_q   <= 1'b1;
                    tx_data_q  <= req_data[int'(win)*DATA_W +: DATA_W];
                    tx_src_q   <= win;
                    ptr_q      <= int'(win) == NUM_REQ - 1 ? '0 : win + 1'b1;
                end
                START: begin
                    state_q <= BUSY;
                    timer_q <= '0;
                end
                BUSY: if (busy_exit) begin
                    // done takes precedence over a coincident timeout
                    state_q  <= GAP_CYCLES == 0 ? IDLE : GAP;
                    active_q <= 1'b0;
                    gap_q    <= '0;
                    if (!tx_done) begin
                        timeout_err_q <= 1'b1;
                        err_cnt_q     <= err_cnt_q == 8'hFF ? err_cnt_q : err_cnt_q + 8'd1;
                    end
                end else begin
                    timer_q <= timer_d;
                end
                GAP: begin
                    gap_q   <= gap_d;
                    state_q <= gap_d == 4'(GAP_CYCLES) ? IDLE : GAP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign gnt         = gnt_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign tx_src      = tx_src_q;
    assign active      = active_q;
    assign timeout_err = timeout_err_q;
    assign err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed checks of grant order, sequencing, guard gap, watchdog and reset.
module tb_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        tx_done = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = 32'h3CA55AC3;
    logic [3:0]  gnt;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  tx_src;
    logic        active;
    logic        timeout_err;
    logic [7:0]  err_cnt;
    logic [7:0]  byte_of [4] = '{8'hC3, 8'h5A, 8'hA5, 8'h3C};
    int          checks = 0;
    int          errors = 0;

    tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(2), .TIMEOUT(10)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
        .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data), .tx_src(tx_src),
        .tx_done(tx_done), .active(active), .timeout_err(timeout_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input int exp_src, output int n);
        n = 0;
        while (tx_start !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 32'(tx_start), 32'd1);
        chk("src", 32'(tx_src), 32'(exp_src));
        chk("gnt", 32'(gnt), 32'd1 << exp_src);
        chk("data", 32'(tx_data), 32'(byte_of[exp_src]));
    endtask

    task automatic run_busy(input int len);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            tx_done = (k == len);
        end
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic wd(output int n);
        int m;
        wait_start(0, m);
        n = 0;
        while (timeout_err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #500us;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, n_act, te_seen, bad, cnt;
        int rr_exp [5] = '{0, 1, 2, 3, 0};
        int wr_exp [4] = '{0, 3, 0, 3};
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_errcnt", 32'(err_cnt), 32'd0);
        rst = 1'b1;
        en = 1'b1;
        @(negedge clk);
        // single source
        req = 4'b0100;
        wait_start(2, n);
        chk("latency", 32'(n), 32'd1);
        n_act = int'(active);
        te_seen = 0;
        req = 4'b0000;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("gnt_pulse", 32'(gnt), 32'd0);
                chk("start_pulse", 32'(tx_start), 32'd0);
            end
            tx_done = (k == 5);
            n_act += int'(active);
            te_seen |= int'(timeout_err);
        end
        @(negedge clk);
        tx_done = 1'b0;
        chk("active_gap", 32'(active), 32'd0);
        chk("active_len", 32'(n_act), 32'd6);
        repeat (3) begin
            @(negedge clk);
            te_seen |= int'(timeout_err);
        end
        chk("single_no_te", 32'(te_seen), 32'd0);
        chk("single_errcnt", 32'(err_cnt), 32'd0);
        // round-robin fairness
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_start(rr_exp[i], n);
            run_busy(3);
        end
        // pointer wrap
        do_reset();
        req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            wait_start(wr_exp[i], n);
            run_busy(3);
        end
        // watchdog and saturation
        do_reset();
        req = 4'b0001;
        wd(n);
        chk("wd_len1", 32'(n), 32'd11);
        chk("wd_cnt1", 32'(err_cnt), 32'd1);
        @(negedge clk);
        chk("te_pulse", 32'(timeout_err), 32'd0);
        wd(n);
        chk("wd_len2", 32'(n), 32'd11);
        chk("wd_cnt2", 32'(err_cnt), 32'd2);
        bad = 0;
        for (int i = 0; i < 298; i++) begin
            wd(n);
            if (n != 11) bad++;
        end
        chk("wd_loop_len", 32'(bad), 32'd0);
        chk("wd_saturate", 32'(err_cnt), 32'd255);
        // done on the last allowed BUSY cycle wins over the timeout
        do_reset();
        req = 4'b0001;
        wait_start(0, n);
        run_busy(10);
        chk("done_wins_te", 32'(timeout_err), 32'd0);
        chk("done_wins_cnt", 32'(err_cnt), 32'd0);
        chk("done_wins_act", 32'(active), 32'd0);
        // enable drop during a transfer
        do_reset();
        req = 4'b0010;
        wait_start(1, n);
        en = 1'b0;
        run_busy(3);
        chk("en_finish", 32'(active), 32'd0);
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            cnt += int'(gnt != 4'b0000 || tx_start);
        end
        chk("en_no_gnt", 32'(cnt), 32'd0);
        en = 1'b1;
        wait_start(1, n);
        run_busy(3);
        wait_start(1, n);
        chk("gap_len", 32'(n), 32'd3);
        run_busy(3);
        // asynchronous reset in BUSY
        do_reset();
        req = 4'b0001;
        wait_start(0, n);
        repeat (2) @(negedge clk);
        chk("mid_active", 32'(active), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_active", 32'(active), 32'd0);
        chk("arst_data", 32'(tx_data), 32'd0);
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_src", 32'(tx_src), 32'd0);
        chk("arst_te", 32'(timeout_err), 32'd0);
        req = 4'b1001;
        @(negedge clk);
        rst = 1'b1;
        wait_start(0, n);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
